// File: rtl/sram_access_seq_pkg.sv
// Shared definitions for the SRAM access sequencer and its neighbours
// (sreg, bus_fsm): default bus widths and the access FSM state encoding.
package sram_access_seq_pkg;

    localparam int SRAM_ADDR_W = 21;
    localparam int SRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/sram_access_seq_if.sv
// Host-side request bus of the SRAM sequencer: address load, access
// request and the completion/readback signals.
interface sram_access_seq_if
    import sram_access_seq_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
);

    logic              addr_load;
    logic [ADDR_W-1:0] addr_in;
    logic              req;
    logic              we;
    logic              inc;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;
    logic [ADDR_W-1:0] cur_addr;

    modport master (
        output addr_load, addr_in, req, we, inc, wdata,
        input  rdata, ack, busy, cur_addr
    );

    modport slave (
        input  addr_load, addr_in, req, we, inc, wdata,
        output rdata, ack, busy, cur_addr
    );

endinterface

// File: rtl/sram_access_seq_addr_reg.sv
// Current SRAM address register: load only while idle, post-increment
// with natural wrap. Exposes its next value so the pin flop can track it.
module sram_addr_reg
    import sram_access_seq_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idle,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              incr,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] nxt_addr
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (idle && load) begin
            addr_d = load_val;
        end else if (incr) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign cur_addr = addr_q;
    assign nxt_addr = addr_d;

endmodule

// File: rtl/sram_access_seq.sv
// SRAM access sequencer: turns single-cycle requests into registered
// CE/OE/WE strobe sequences (SETUP, STROBE x N, HOLD) and latches read data.
module sram_access_seq
    import sram_access_seq_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int STROBE_CYC = 2
) (
    input  logic              avr_clk,
    input  logic              avr_reset_n,
    sram_access_seq_if.slave  bus,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int             CNT_W    = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYC - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc_we_q, acc_we_d;
    logic              acc_inc_q, acc_inc_d;
    logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              drv_q, drv_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;

    logic              idle;
    logic              incr;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] nxt_addr;

    assign idle = (state_q == S_IDLE);
    assign incr = (state_q == S_HOLD) && acc_inc_q;

    sram_addr_reg #(
        .ADDR_W (ADDR_W)
    ) u_addr_reg (
        .clk      (avr_clk),
        .rst_n    (avr_reset_n),
        .idle     (idle),
        .load     (bus.addr_load),
        .load_val (bus.addr_in),
        .incr     (incr),
        .cur_addr (cur_addr),
        .nxt_addr (nxt_addr)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_we_d   = acc_we_q;
        acc_inc_d  = acc_inc_q;
        acc_addr_d = acc_addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    state_d    = S_SETUP;
                    acc_we_d   = bus.we;
                    acc_inc_d  = bus.inc;
                    wdata_d    = bus.wdata;
                    acc_addr_d = bus.addr_load ? bus.addr_in : cur_addr;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = CNT_LOAD;
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    if (!acc_we_q) begin
                        rdata_d = sram_data;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Pin flops are loaded from the next state so every output is registered.
        ce_n_d      = (state_d == S_IDLE);
        oe_n_d      = !((state_d == S_STROBE) && !acc_we_d);
        we_n_d      = !((state_d == S_STROBE) && acc_we_d);
        drv_d       = (state_d != S_IDLE) && acc_we_d;
        ack_d       = (state_d == S_HOLD);
        busy_d      = (state_d != S_IDLE);
        sram_addr_d = (state_d == S_IDLE) ? nxt_addr : acc_addr_d;
    end

    always_ff @(posedge avr_clk or negedge avr_reset_n) begin
        if (!avr_reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_we_q    <= 1'b0;
            acc_inc_q   <= 1'b0;
            rdata_q     <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            drv_q       <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_we_q    <= acc_we_d;
            acc_inc_q   <= acc_inc_d;
            rdata_q     <= rdata_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            drv_q       <= drv_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    // Access address and write data are only meaningful while drv/CE qualify them.
    always_ff @(posedge avr_clk) begin
        acc_addr_q <= acc_addr_d;
        wdata_q    <= wdata_d;
    end

    assign sram_data    = drv_q ? wdata_q : {DATA_W{1'bz}};
    assign sram_addr    = sram_addr_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_we_n    = we_n_q;
    assign bus.rdata    = rdata_q;
    assign bus.ack      = ack_q;
    assign bus.busy     = busy_q;
    assign bus.cur_addr = cur_addr;

endmodule

// File: tb/tb_sram_access_seq.sv
// Directed bench for sram_access_seq: table of single accesses plus
// hand-written reset, back-to-back, mid-access and async-reset sequences.
module tb_sram_access_seq;

    localparam int AW = 21;
    localparam int DW = 8;
    localparam int SC = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_access_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;
    logic          ce_n, oe_n, we_n;

    sram_access_seq #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STROBE_CYC (SC)
    ) dut (
        .avr_clk     (clk),
        .avr_reset_n (rst_n),
        .bus         (bus_if),
        .sram_addr   (sram_addr),
        .sram_data   (sram_data),
        .sram_ce_n   (ce_n),
        .sram_oe_n   (oe_n),
        .sram_we_n   (we_n)
    );

    // SRAM model: drives read data while selected with OE low; float_chk
    // drives a marker so an undriven bus reads back as that marker.
    logic          float_chk;
    logic [DW-1:0] rd_val;
    logic          mdl_en;
    logic [DW-1:0] mdl_val;

    always_comb begin
        mdl_en  = float_chk || (!ce_n && !oe_n);
        mdl_val = float_chk ? 8'h3C : rd_val;
    end
    assign sram_data = mdl_en ? mdl_val : {DW{1'bz}};

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic float_check(input string name);
        float_chk = 1'b1;
        #1;
        chk(name, 32'(sram_data), 32'h3C);
        float_chk = 1'b0;
        #1;
    endtask

    // Called at a negedge; issues one request and observes cycles N+1..N+5.
    // Returns in the middle of cycle N+5 so the next call is back-to-back.
    task automatic access(input logic ld, input logic [AW-1:0] a, input logic w,
                          input logic i, input logic [DW-1:0] wd, input logic [DW-1:0] rv,
                          input logic [AW-1:0] exp_acc, input logic [DW-1:0] exp_rd,
                          input logic [AW-1:0] exp_cur, input bit poke);
        int ack_first;
        int ack_cnt;
        bit strobe_ok;
        bit busy_ok;
        bit ce_ok;
        bit addr_ok;
        bit data_ok;
        ack_first = 0;
        ack_cnt   = 0;
        strobe_ok = 1'b1;
        busy_ok   = 1'b1;
        ce_ok     = 1'b1;
        addr_ok   = 1'b1;
        data_ok   = 1'b1;
        rd_val    = rv;
        bus_if.addr_load = ld;
        bus_if.addr_in   = a;
        bus_if.req       = 1'b1;
        bus_if.we        = w;
        bus_if.inc       = i;
        bus_if.wdata     = wd;
        @(negedge clk);
        bus_if.req       = 1'b0;
        bus_if.addr_load = 1'b0;
        for (int k = 1; k <= SC + 3; k++) begin
            if (bus_if.ack) begin
                ack_cnt++;
                if (ack_first == 0) ack_first = k;
            end
            if (oe_n !== !(!w && k >= 2 && k <= SC + 1)) strobe_ok = 1'b0;
            if (we_n !== !(w && k >= 2 && k <= SC + 1)) strobe_ok = 1'b0;
            if (bus_if.busy !== (k <= SC + 2)) busy_ok = 1'b0;
            if (ce_n !== !(k <= SC + 2)) ce_ok = 1'b0;
            if (k <= SC + 2 && sram_addr !== exp_acc) addr_ok = 1'b0;
            if (w && k <= SC + 2 && sram_data !== wd) data_ok = 1'b0;
            if (poke && k == 2) begin
                bus_if.req       = 1'b1;
                bus_if.addr_load = 1'b1;
                bus_if.addr_in   = 21'h01555;
                bus_if.we        = 1'b1;
                bus_if.wdata     = 8'h99;
            end
            if (poke && k == 3) begin
                bus_if.req       = 1'b0;
                bus_if.addr_load = 1'b0;
            end
            if (k < SC + 3) @(negedge clk);
        end
        chk("ack_latency", 32'(ack_first), 32'(SC + 2));
        chk("ack_pulses", 32'(ack_cnt), 32'd1);
        chk("strobe_window", 32'(strobe_ok), 32'd1);
        chk("busy_window", 32'(busy_ok), 32'd1);
        chk("ce_window", 32'(ce_ok), 32'd1);
        chk("access_addr", 32'(addr_ok), 32'd1);
        if (w) chk("wdata_driven", 32'(data_ok), 32'd1);
        chk("rdata", 32'(bus_if.rdata), 32'(exp_rd));
        chk("cur_addr", 32'(bus_if.cur_addr), 32'(exp_cur));
        chk("idle_sram_addr", 32'(sram_addr), 32'(exp_cur));
        float_check("idle_bus_release");
    endtask

    typedef struct {
        logic          ld;
        logic [AW-1:0] addr;
        logic          we;
        logic          inc;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rd_val;
        logic [AW-1:0] exp_acc;
        logic [DW-1:0] exp_rd;
        logic [AW-1:0] exp_cur;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit ack_seen;
        bit busy_seen;

        vecs[0] = '{1'b1, 21'h0ABCD,  1'b0, 1'b0, 8'h00, 8'hAA, 21'h0ABCD,  8'hAA, 21'h0ABCD};
        vecs[1] = '{1'b1, 21'h1FFFFF, 1'b1, 1'b1, 8'hEE, 8'h00, 21'h1FFFFF, 8'hAA, 21'h000000};
        vecs[2] = '{1'b0, 21'h12345,  1'b0, 1'b1, 8'h00, 8'h55, 21'h000000,  8'h55, 21'h000001};
        vecs[3] = '{1'b0, 21'h00000,  1'b1, 1'b0, 8'h12, 8'h00, 21'h000001,  8'h55, 21'h000001};
        vecs[4] = '{1'b1, 21'h15A5A,  1'b0, 1'b1, 8'h00, 8'hC3, 21'h15A5A,   8'hC3, 21'h15A5B};

        rst_n            = 1'b0;
        float_chk        = 1'b0;
        rd_val           = '0;
        bus_if.addr_load = 1'b0;
        bus_if.addr_in   = '0;
        bus_if.req       = 1'b1;
        bus_if.we        = 1'b0;
        bus_if.inc       = 1'b0;
        bus_if.wdata     = '0;

        // Reset held with req high
        repeat (3) @(negedge clk);
        chk("rst_ce_n", 32'(ce_n), 32'd1);
        chk("rst_oe_n", 32'(oe_n), 32'd1);
        chk("rst_we_n", 32'(we_n), 32'd1);
        chk("rst_ack", 32'(bus_if.ack), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_cur_addr", 32'(bus_if.cur_addr), 32'd0);
        chk("rst_rdata", 32'(bus_if.rdata), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        float_check("rst_bus_release");

        bus_if.req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ack_seen  = 1'b0;
        busy_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus_if.ack) ack_seen = 1'b1;
            if (bus_if.busy) busy_seen = 1'b1;
        end
        chk("post_rst_no_ack", 32'(ack_seen), 32'd0);
        chk("post_rst_no_busy", 32'(busy_seen), 32'd0);

        for (int v = 0; v < 5; v++) begin
            access(vecs[v].ld, vecs[v].addr, vecs[v].we, vecs[v].inc, vecs[v].wdata,
                   vecs[v].rd_val, vecs[v].exp_acc, vecs[v].exp_rd, vecs[v].exp_cur, 1'b0);
        end

        // Four back-to-back incrementing reads from 0x10
        for (int b = 0; b < 4; b++) begin
            access(b == 0, 21'h00010, 1'b0, 1'b1, 8'h00, 8'hD0 + 8'(b),
                   21'h00010 + 21'(b), 8'hD0 + 8'(b), 21'h00011 + 21'(b), 1'b0);
        end
        chk("b2b_final_addr", 32'(bus_if.cur_addr), 32'h14);

        // req and addr_load pulsed mid-access are dropped
        access(1'b0, 21'h00000, 1'b0, 1'b0, 8'h00, 8'h5A, 21'h00014, 8'h5A, 21'h00014, 1'b1);
        @(negedge clk);
        chk("poke_not_queued", 32'(bus_if.busy), 32'd0);
        chk("poke_addr_kept", 32'(bus_if.cur_addr), 32'h14);

        // Asynchronous reset during STROBE
        rd_val           = 8'h77;
        bus_if.req       = 1'b1;
        bus_if.we        = 1'b0;
        bus_if.inc       = 1'b1;
        @(negedge clk);
        bus_if.req = 1'b0;
        @(negedge clk);
        chk("pre_areset_oe", 32'(oe_n), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_oe_n", 32'(oe_n), 32'd1);
        chk("areset_ce_n", 32'(ce_n), 32'd1);
        chk("areset_we_n", 32'(we_n), 32'd1);
        chk("areset_busy", 32'(bus_if.busy), 32'd0);
        chk("areset_rdata", 32'(bus_if.rdata), 32'd0);
        float_check("areset_bus_release");
        ack_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus_if.ack) ack_seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus_if.ack) ack_seen = 1'b1;
        end
        chk("areset_no_ack", 32'(ack_seen), 32'd0);
        chk("areset_idle", 32'(bus_if.busy), 32'd0);
        chk("areset_cur_addr", 32'(bus_if.cur_addr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
